// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants and helpers for the piano note scheduler
package piano_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int TICK_HZ       = 20000;
    localparam int DEB_TICKS_DEF = 200;
    localparam int GAP_TICKS_DEF = 40;

    localparam logic [7:0] HP0_DEF = 8'd76;
    localparam logic [7:0] HP1_DEF = 8'd68;
    localparam logic [7:0] HP2_DEF = 8'd60;
    localparam logic [7:0] HP3_DEF = 8'd57;

    // Returns {hit, index} of the lowest set bit.
    function automatic logic [2:0] lowest_set(input logic [3:0] v);
        lowest_set = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_set = {1'b1, 2'(i)};
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, tick-based debounce and press pulse
module key_debounce
    import piano_pkg::*;
#(
    parameter int DEB_TICKS = DEB_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw,
    output logic db,
    output logic press
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic          sync1;
    logic          sync2;
    logic          db_q;
    logic          held;
    logic [CW-1:0] cnt;

    // Synchronizer idles at 1 so a reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
        end
    end

    assign held = ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            db_q <= db;
            if (held == db) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(DEB_TICKS - 1)) begin
                    db  <= ~db;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/piano_note_scheduler.sv
// rtl/piano_note_scheduler.sv - last-pressed-wins note selection with silent gap between notes
module piano_note_scheduler
    import piano_pkg::*;
#(
    parameter int         DEB_TICKS = DEB_TICKS_DEF,
    parameter int         GAP_TICKS = GAP_TICKS_DEF,
    parameter logic [7:0] HP0       = HP0_DEF,
    parameter logic [7:0] HP1       = HP1_DEF,
    parameter logic [7:0] HP2       = HP2_DEF,
    parameter logic [7:0] HP3       = HP3_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] sw,
    output logic       note_on,
    output logic [1:0] note_idx,
    output logic [7:0] half_period,
    output logic [3:0] keys_db
);

    localparam int GW = $clog2(GAP_TICKS + 1);

    logic [3:0]    press;
    logic [1:0]    state;
    logic [1:0]    target;
    logic [GW-1:0] gap_cnt;
    logic          new_hit;
    logic          fb_hit;
    logic [1:0]    new_idx;
    logic [1:0]    fb_idx;
    logic [1:0]    gap_pick;
    logic [1:0]    play_idx;
    logic          play_ok;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .sw    (sw[i]),
            .db    (keys_db[i]),
            .press (press[i])
        );
    end

    function automatic logic [7:0] hp_of(input logic [1:0] idx);
        case (idx)
            2'd0:    hp_of = HP0;
            2'd1:    hp_of = HP1;
            2'd2:    hp_of = HP2;
            default: hp_of = HP3;
        endcase
    endfunction

    assign {new_hit, new_idx} = lowest_set(press);
    assign {fb_hit, fb_idx}   = lowest_set(keys_db);

    // A press on the very last gap tick still redirects the gap's target.
    assign gap_pick = new_hit ? new_idx : target;
    assign play_ok  = keys_db[gap_pick] | fb_hit;
    assign play_idx = keys_db[gap_pick] ? gap_pick : fb_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            note_on     <= 1'b0;
            note_idx    <= 2'd0;
            half_period <= HP0;
            target      <= 2'd0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_hit) begin
                        state       <= ST_PLAY;
                        note_on     <= 1'b1;
                        note_idx    <= new_idx;
                        half_period <= hp_of(new_idx);
                    end
                end
                ST_PLAY: begin
                    if (new_hit) begin
                        state   <= ST_GAP;
                        note_on <= 1'b0;
                        target  <= new_idx;
                        gap_cnt <= '0;
                    end else if (!keys_db[note_idx]) begin
                        state   <= fb_hit ? ST_GAP : ST_IDLE;
                        note_on <= 1'b0;
                        target  <= fb_idx;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    target <= gap_pick;
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                            gap_cnt <= '0;
                            if (play_ok) begin
                                state       <= ST_PLAY;
                                note_on     <= 1'b1;
                                note_idx    <= play_idx;
                                half_period <= hp_of(play_idx);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    note_on <= 1'b0;
                end
            endcase
        end
    end

endmodule
